// File: rtl/lfsr_prbs_check.sv
// Self-synchronizing PRBS checker: predicts each received bit from earlier received bits,
// flags per-bit mismatches, tracks lock and keeps a saturating bit-error count.
module lfsr_prbs_check #(
    parameter int                    LFSR_WIDTH   = 9,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 9'h021,
    parameter int                    REVERSE      = 0,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    LOCK_COUNT   = 16,
    parameter int                    UNLOCK_COUNT = 4,
    parameter int                    COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    input  logic                   clear_count,
    output logic [DATA_WIDTH-1:0]  error_out,
    output logic                   error_valid,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam int FILL_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int FILL_W     = $clog2(FILL_WORDS + 1);
    localparam int GOOD_W     = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W      = $clog2(UNLOCK_COUNT + 1);
    localparam int SEQ_W      = LFSR_WIDTH + DATA_WIDTH;
    localparam int PC_W       = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_HUNT   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [1:0]             state;
    logic [FILL_W-1:0]      fill_cnt;
    logic [GOOD_W-1:0]      good_cnt;
    logic [BAD_W-1:0]       bad_cnt;
    // hist[0] is the oldest received bit, hist[LFSR_WIDTH-1] the newest
    logic [LFSR_WIDTH-1:0]  hist;

    logic [DATA_WIDTH-1:0]  tbits_p0;
    logic [SEQ_W-1:0]       seq_p0;
    logic [DATA_WIDTH-1:0]  mism_t_p0;
    logic [DATA_WIDTH-1:0]  mism_p0;
    logic [LFSR_WIDTH-1:0]  hist_nxt_p0;
    logic                   err_p0;
    logic                   clean_p0;
    logic [PC_W-1:0]        pc_p0;
    logic [COUNT_WIDTH-1:0] cnt_nxt_p0;

    function automatic logic [PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [PC_W-1:0] pc;
        pc = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            pc = pc + PC_W'(v[i]);
        return pc;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [PC_W-1:0] b);
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, a} + (COUNT_WIDTH + 1)'(b);
        if (s[COUNT_WIDTH])
            return '1;
        return s[COUNT_WIDTH-1:0];
    endfunction

    // Stage p0: time-ordered bits, per-bit prediction across history and the word itself
    always_comb begin
        tbits_p0  = '0;
        mism_t_p0 = '0;
        mism_p0   = '0;
        for (int t = 0; t < DATA_WIDTH; t++)
            tbits_p0[t] = (REVERSE != 0) ? data_in[t] : data_in[DATA_WIDTH-1-t];
        seq_p0 = {tbits_p0, hist};
        for (int t = 0; t < DATA_WIDTH; t++) begin
            logic pred;
            pred = 1'b0;
            for (int k = 0; k < LFSR_WIDTH; k++)
                if (LFSR_POLY[k])
                    pred = pred ^ seq_p0[t+k];
            mism_t_p0[t] = pred ^ tbits_p0[t];
        end
        for (int t = 0; t < DATA_WIDTH; t++) begin
            if (REVERSE != 0)
                mism_p0[t] = mism_t_p0[t];
            else
                mism_p0[DATA_WIDTH-1-t] = mism_t_p0[t];
        end
        hist_nxt_p0 = seq_p0[DATA_WIDTH +: LFSR_WIDTH];
    end

    // An all-zero word over an all-zero history satisfies the recurrence trivially
    assign err_p0   = |mism_p0;
    assign clean_p0 = !err_p0 && !((data_in == '0) && (hist == '0));
    assign pc_p0    = popcount(mism_p0);

    always_comb begin
        cnt_nxt_p0 = clear_count ? '0 : error_count;
        if (data_in_valid && (state == S_LOCKED))
            cnt_nxt_p0 = sat_add(cnt_nxt_p0, pc_p0);
    end

    // Stage p1: registered outputs, history and lock FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FILL;
            fill_cnt    <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            hist        <= '0;
            error_out   <= '0;
            error_valid <= 1'b0;
            error_count <= '0;
        end else begin
            error_count <= cnt_nxt_p0;
            error_valid <= data_in_valid && (state != S_FILL);
            error_out   <= (data_in_valid && (state != S_FILL)) ? mism_p0 : '0;
            if (data_in_valid) begin
                hist <= hist_nxt_p0;
                case (state)
                    S_FILL: begin
                        if (fill_cnt == FILL_W'(FILL_WORDS - 1)) begin
                            state    <= S_HUNT;
                            fill_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    S_HUNT: begin
                        if (!clean_p0) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                            state    <= S_LOCKED;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (!err_p0) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt == BAD_W'(UNLOCK_COUNT - 1)) begin
                            state    <= S_HUNT;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                    default: state <= S_FILL;
                endcase
            end
        end
    end

    assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Randomized scoreboard bench for lfsr_prbs_check (PRBS9, 8-bit words, 32- and 4-bit counters).
module tb_lfsr_prbs_check;
    localparam int W  = 9;
    localparam int D  = 8;
    localparam int LC = 16;
    localparam int UC = 4;
    localparam int FILL_WORDS = 2;
    localparam logic [W-1:0] POLY = 9'h021;
    localparam longint MAX32 = 64'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic [D-1:0] data_in;
    logic         data_in_valid;
    logic         clear_count;
    logic [D-1:0] error_out, error_out4;
    logic         error_valid, error_valid4;
    logic         locked, locked4;
    logic [31:0]  error_count;
    logic [3:0]   error_count4;

    always #5 clk = ~clk;

    lfsr_prbs_check dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .clear_count(clear_count), .error_out(error_out), .error_valid(error_valid),
        .locked(locked), .error_count(error_count)
    );

    lfsr_prbs_check #(.COUNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .clear_count(clear_count), .error_out(error_out4), .error_valid(error_valid4),
        .locked(locked4), .error_count(error_count4)
    );

    typedef struct {
        logic [D-1:0] eo;
        logic         lk;
        longint       c32;
        longint       c4;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    // reference model: received-bit window, lock state, counters
    bit     m_hist[$];
    int     m_state, m_fill, m_good, m_bad, m_last_pc;
    longint m_c32, m_c4;
    bit     g_hist[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
        m_state = 0; m_fill = 0; m_good = 0; m_bad = 0;
        m_c32 = 0; m_c4 = 0; m_last_pc = 0;
    endtask

    task automatic gen_reset();
        g_hist.delete();
        for (int i = 0; i < W; i++) g_hist.push_back(1'b1);
    endtask

    // next PRBS word; earliest bit lands in the MSB
    task automatic gen_word(output logic [D-1:0] w);
        bit nb;
        w = '0;
        for (int t = 0; t < D; t++) begin
            nb = 1'b0;
            for (int k = 0; k < W; k++) if (POLY[k]) nb ^= g_hist[k];
            g_hist.push_back(nb);
            void'(g_hist.pop_front());
            w[D-1-t] = nb;
        end
    endtask

    task automatic model_word(input logic [D-1:0] w, input bit clr);
        logic [D-1:0] mask;
        bit zero, b, p;
        int st0;
        exp_t e;
        mask = '0;
        st0  = m_state;
        zero = (w == '0);
        foreach (m_hist[i]) if (m_hist[i]) zero = 1'b0;
        for (int t = 0; t < D; t++) begin
            b = w[D-1-t];
            p = 1'b0;
            for (int k = 0; k < W; k++) if (POLY[k]) p ^= m_hist[k];
            if (p != b) mask[D-1-t] = 1'b1;
            m_hist.push_back(b);
            void'(m_hist.pop_front());
        end
        m_last_pc = $countones(mask);
        if (clr) begin m_c32 = 0; m_c4 = 0; end
        if (st0 == 2) begin
            m_c32 = (m_c32 + m_last_pc > MAX32) ? MAX32 : m_c32 + m_last_pc;
            m_c4  = (m_c4 + m_last_pc > 15) ? 15 : m_c4 + m_last_pc;
        end
        case (m_state)
            0: begin
                m_fill++;
                if (m_fill == FILL_WORDS) begin m_state = 1; m_fill = 0; end
            end
            1: begin
                if (mask != 0 || zero) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == LC) begin m_state = 2; m_good = 0; m_bad = 0; end
                end
            end
            default: begin
                if (mask == 0) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == UC) begin m_state = 1; m_good = 0; m_bad = 0; end
                end
            end
        endcase
        if (st0 != 0) begin
            e.eo = mask; e.lk = (m_state == 2); e.c32 = m_c32; e.c4 = m_c4;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [D-1:0] w, input bit clr);
        @(posedge clk); #1;
        data_in = w; data_in_valid = 1'b1; clear_count = clr;
        model_word(w, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            data_in = D'($urandom); data_in_valid = 1'b0; clear_count = 1'b0;
        end
    endtask

    task automatic send_prbs(input int n);
        logic [D-1:0] w;
        repeat (n) begin gen_word(w); send(w, 1'b0); end
    endtask

    task automatic settle();
        idle(1);
        @(negedge clk);
    endtask

    task automatic reset_midcycle();
        idle(1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_error_out", error_out, 0);
        chk("rst_error_valid", error_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_error_count", error_count, 0);
        chk("rst_error_count4", error_count4, 0);
        sb_q.delete();
        model_reset();
        gen_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && error_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: error_valid=1 with no pending word at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("error_out", error_out, mon_e.eo);
                chk("locked", locked, mon_e.lk);
                chk("error_count", error_count, mon_e.c32);
                chk("error_count4", error_count4, mon_e.c4);
            end
        end
    end

    initial begin
        logic [D-1:0] w, m;
        int last_flip;
        longint c0, sum_pc;

        rst = 1'b1; data_in = '0; data_in_valid = 1'b0; clear_count = 1'b0;
        model_reset();
        gen_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_error_out", error_out, 0);
        chk("init_error_valid", error_valid, 0);
        chk("init_locked", locked, 0);
        chk("init_error_count", error_count, 0);
        rst = 1'b0;

        // clean lock, valid every cycle
        send_prbs(2);
        settle();
        chk("fill_locked_low", locked, 0);
        send_prbs(16);
        settle();
        chk("locked_after_18", locked, 1);
        send_prbs(982);
        settle();
        chk("clean_locked", locked, 1);
        chk("clean_count", error_count, 0);

        // single flipped bit while locked
        gen_word(w);
        w ^= D'(1) << $urandom_range(0, D - 1);
        send(w, 1'b0);
        send_prbs(5);
        settle();
        chk("flip_count", error_count, 3);
        chk("flip_locked", locked, 1);

        // four errored words drop lock, then relock
        sum_pc = 0;
        for (int i = 0; i < UC; i++) begin
            gen_word(w);
            m = D'($urandom_range(1, (1 << D) - 1));
            send(w ^ m, 1'b0);
            sum_pc += m_last_pc;
        end
        settle();
        chk("unlock_locked", locked, 0);
        chk("unlock_count", error_count, 3 + sum_pc);
        send_prbs(40);
        settle();
        chk("relock_locked", locked, 1);

        // clear on an errored word keeps only that word's errors
        gen_word(w);
        m = D'($urandom_range(1, (1 << D) - 1));
        send(w ^ m, 1'b1);
        c0 = m_last_pc;
        settle();
        chk("clear_errored_count", error_count, c0);
        send_prbs(5);
        gen_word(w);
        send(w, 1'b1);
        settle();
        chk("clear_clean_count", error_count, 0);

        // 24 errors: 32-bit counter tracks, 4-bit counter saturates
        for (int i = 0; i < 8; i++) begin
            gen_word(w);
            w ^= D'(1) << $urandom_range(0, D - 1);
            send(w, 1'b0);
            send_prbs(4);
        end
        settle();
        chk("sat_count32", error_count, 24);
        chk("sat_count4", error_count4, 15);
        chk("sat_locked", locked, 1);

        // reset mid-stream, then random valid gaps with sparse bit errors
        reset_midcycle();
        send_prbs(2);
        settle();
        chk("gap_fill_locked_low", locked, 0);
        last_flip = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            gen_word(w);
            if (i > 100 && i - last_flip > 10 && $urandom_range(0, 59) == 0) begin
                w ^= D'(1) << $urandom_range(0, D - 1);
                last_flip = i;
            end
            send(w, 1'b0);
        end
        send_prbs(4);
        settle();
        chk("gap_locked", locked, 1);

        // all-zero input never locks
        reset_midcycle();
        for (int i = 0; i < 100; i++) send('0, 1'b0);
        settle();
        chk("zero_locked", locked, 0);
        chk("zero_count", error_count, 0);

        idle(3);
        @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
